// File: rtl/hold_counter_pkg.sv
// Shared types and reset defaults for the dwelling up/down counter.
package hold_counter_pkg;

  typedef enum logic {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int PKG_WIDTH    = 3;
  localparam int PKG_HOLD_W   = 2;
  localparam int PKG_HOLD_VAL = 5;
  localparam int PKG_HOLD_LEN = 1;

endpackage

// File: rtl/hold_counter.sv
// Wrapping up/down counter that dwells on hold_val for hold_len extra enabled cycles.
// All outputs registered; one edge of latency from any input.
module hold_counter
  import hold_counter_pkg::*;
#(
  parameter int WIDTH        = PKG_WIDTH,
  parameter int MAX_VAL      = 2**WIDTH - 1,
  parameter int HOLD_W       = PKG_HOLD_W,
  parameter int DEF_HOLD_VAL = PKG_HOLD_VAL,
  parameter int DEF_HOLD_LEN = PKG_HOLD_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              cfg_wr,
  input  logic [WIDTH-1:0]  cfg_hold_val,
  input  logic [HOLD_W-1:0] cfg_hold_len,
  output logic [WIDTH-1:0]  y,
  output logic              holding,
  output logic              wrap
);

  localparam logic [WIDTH-1:0] MAX_Y = WIDTH'(MAX_VAL);

  // Returns {wrapped, next_value}.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] cur, input logic down);
    if (down)
      return (cur == '0) ? {1'b1, MAX_Y} : {1'b0, cur - WIDTH'(1)};
    else
      return (cur == MAX_Y) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, cur + WIDTH'(1)};
  endfunction

  state_t             state, state_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic [WIDTH-1:0]   hold_val;
  logic [HOLD_W-1:0]  hold_len;
  logic [WIDTH-1:0]   y_n;
  logic               wrap_n;
  logic [WIDTH:0]     stepped;

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    y_n        = y;
    wrap_n     = 1'b0;
    stepped    = step(y, dir);
    // A config write abandons any dwell so the new settings start cleanly.
    if (cfg_wr) begin
      state_n    = COUNT;
      hold_cnt_n = '0;
    end else if (en) begin
      unique case (state)
        COUNT: begin
          if (y == hold_val && hold_len != '0) begin
            state_n    = HOLD;
            hold_cnt_n = HOLD_W'(1);
          end else begin
            y_n    = stepped[WIDTH-1:0];
            wrap_n = stepped[WIDTH];
          end
        end
        HOLD: begin
          if (hold_cnt == hold_len) begin
            state_n    = COUNT;
            hold_cnt_n = '0;
            y_n        = stepped[WIDTH-1:0];
            wrap_n     = stepped[WIDTH];
          end else begin
            hold_cnt_n = hold_cnt + HOLD_W'(1);
          end
        end
        default: state_n = COUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COUNT;
      hold_cnt <= '0;
      y        <= '0;
      holding  <= 1'b0;
      wrap     <= 1'b0;
      hold_val <= WIDTH'(DEF_HOLD_VAL);
      hold_len <= HOLD_W'(DEF_HOLD_LEN);
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      y        <= y_n;
      holding  <= (state_n == HOLD);
      wrap     <= wrap_n;
      if (cfg_wr) begin
        hold_val <= cfg_hold_val;
        hold_len <= cfg_hold_len;
      end
    end
  end

endmodule
